spu_writeback_pipe: RTL and testbench

Dual-lane (even/odd) result-staging and forwarding pipe for the SPU. It sits between the even/odd execution units and the register file write ports. Each issued instruction is tracked from issue through stage DEPTH, and its result is captured when the unit completes. The block presents the register file write bus (rt, rt_addr, reg_write) per lane at stage DEPTH and serves ready results to operand-fetch forwarding queries.

---
 rtl/spu_writeback_pipe_pkg.sv | 45 ++++
 rtl/spu_writeback_pipe_if.sv | 55 +++++
 rtl/spu_writeback_pipe_lane.sv | 64 ++++++
 rtl/spu_writeback_pipe.sv | 107 ++++++++++
 tb/tb_spu_writeback_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_writeback_pipe_pkg.sv
// Shared sizes, entry/match types and the per-lane youngest-match helper
// for the SPU dual-lane writeback/forwarding pipe.
package spu_wb_pkg;

   localparam int unsigned DEPTH   = 7;
   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned DATA_W  = 128;
   localparam int unsigned NQ      = 6;
   localparam int unsigned STAGE_W = 3;

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic              ready;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Stages visible to operand-fetch forwarding (stage 1 is never forwarded).
   typedef wb_entry_t [DEPTH:2] fwd_stages_t;

   typedef struct packed {
      logic               hit;
      logic [STAGE_W-1:0] stage;
      logic               ready;
      logic [DATA_W-1:0]  data;
   } fwd_match_t;

   function automatic fwd_match_t youngest_match(input fwd_stages_t       st,
                                                 input logic [ADDR_W-1:0] addr);
      fwd_match_t m;
      m = '0;
      // Walk oldest to youngest so the lowest matching stage is kept last.
      for (int k = int'(DEPTH); k >= 2; k--) begin
         if (st[k].valid && st[k].wr && (st[k].addr == addr)) begin
            m.hit   = 1'b1;
            m.stage = STAGE_W'(k);
            m.ready = st[k].ready;
            m.data  = st[k].data;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/spu_writeback_pipe_if.sv
// Issue/result/writeback/forwarding bus between the SPU execution lanes,
// the writeback pipe and the register file.
interface spu_writeback_pipe_if;
   import spu_wb_pkg::*;

   logic                           issue_valid_even;
   logic [ADDR_W-1:0]              issue_addr_even;
   logic                           issue_wr_even;
   logic                           issue_valid_odd;
   logic [ADDR_W-1:0]              issue_addr_odd;
   logic                           issue_wr_odd;

   logic                           res_valid_even;
   logic [STAGE_W-1:0]             res_stage_even;
   logic [DATA_W-1:0]              res_data_even;
   logic                           res_valid_odd;
   logic [STAGE_W-1:0]             res_stage_odd;
   logic [DATA_W-1:0]              res_data_odd;

   logic [DATA_W-1:0]              rt_even;
   logic [ADDR_W-1:0]              rt_addr_even;
   logic                           reg_write_even;
   logic [DATA_W-1:0]              rt_odd;
   logic [ADDR_W-1:0]              rt_addr_odd;
   logic                           reg_write_odd;

   logic [NQ-1:0][ADDR_W-1:0]      fwd_addr;
   logic [NQ-1:0]                  fwd_hit;
   logic [NQ-1:0][DATA_W-1:0]      fwd_data;
   logic [NQ-1:0]                  fwd_stall;
   logic                           err;

   modport master (
      output issue_valid_even, issue_addr_even, issue_wr_even,
      output issue_valid_odd,  issue_addr_odd,  issue_wr_odd,
      output res_valid_even,   res_stage_even,  res_data_even,
      output res_valid_odd,    res_stage_odd,   res_data_odd,
      output fwd_addr,
      input  rt_even, rt_addr_even, reg_write_even,
      input  rt_odd,  rt_addr_odd,  reg_write_odd,
      input  fwd_hit, fwd_data, fwd_stall, err
   );

   modport slave (
      input  issue_valid_even, issue_addr_even, issue_wr_even,
      input  issue_valid_odd,  issue_addr_odd,  issue_wr_odd,
      input  res_valid_even,   res_stage_even,  res_data_even,
      input  res_valid_odd,    res_stage_odd,   res_data_odd,
      input  fwd_addr,
      output rt_even, rt_addr_even, reg_write_even,
      output rt_odd,  rt_addr_odd,  reg_write_odd,
      output fwd_hit, fwd_data, fwd_stall, err
   );

endinterface

// File: rtl/spu_writeback_pipe_lane.sv
// One lane of the writeback pipe: stage shift array, result capture,
// register-file write outputs and lane-local protocol error detection.
module spu_wb_lane
   import spu_wb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               issue_valid_i,
   input  logic [ADDR_W-1:0]  issue_addr_i,
   input  logic               issue_wr_i,
   input  logic               res_valid_i,
   input  logic [STAGE_W-1:0] res_stage_i,
   input  logic [DATA_W-1:0]  res_data_i,
   output fwd_stages_t        fwd_stages_o,
   output logic [DATA_W-1:0]  rt_o,
   output logic [ADDR_W-1:0]  rt_addr_o,
   output logic               reg_write_c_o,
   output logic               err_c_o
);

   wb_entry_t [DEPTH:1] stage_q;
   wb_entry_t [DEPTH:1] stage_d;
   logic                res_hit_c;
   logic                tail_unready_c;

   // Shift every stage by one; a result tags the entry as it leaves its stage.
   always_comb begin
      stage_d    = stage_q;
      res_hit_c  = 1'b0;
      stage_d[1] = '0;
      if (issue_valid_i) begin
         stage_d[1].valid = 1'b1;
         stage_d[1].wr    = issue_wr_i;
         stage_d[1].addr  = issue_addr_i;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
         stage_d[k+1] = stage_q[k];
         if (res_valid_i && (res_stage_i == STAGE_W'(k)) && stage_q[k].valid) begin
            stage_d[k+1].ready = 1'b1;
            stage_d[k+1].data  = res_data_i;
            res_hit_c          = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tail_unready_c = stage_q[DEPTH].valid & stage_q[DEPTH].wr & ~stage_q[DEPTH].ready;

   assign fwd_stages_o  = stage_q[DEPTH:2];
   assign rt_o          = stage_q[DEPTH].data;
   assign rt_addr_o     = stage_q[DEPTH].addr;
   assign reg_write_c_o = stage_q[DEPTH].valid & stage_q[DEPTH].wr & stage_q[DEPTH].ready;

   // Out-of-range stages never match in the loop, so they surface as a miss.
   assign err_c_o = (res_valid_i & ~res_hit_c) | tail_unready_c;

endmodule

// File: rtl/spu_writeback_pipe.sv
// SPU dual-lane writeback pipe: two staging lanes, cross-lane forwarding
// priority, same-address writeback collision check and sticky error flag.
module spu_writeback_pipe
   import spu_wb_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   spu_writeback_pipe_if.slave bus
);

   fwd_stages_t          stages_even;
   fwd_stages_t          stages_odd;
   logic [ADDR_W-1:0]    rt_addr_even;
   logic [ADDR_W-1:0]    rt_addr_odd;
   logic                 reg_write_even_c;
   logic                 reg_write_odd_c;
   logic                 err_even_c;
   logic                 err_odd_c;
   logic                 collide_c;
   logic                 err_q;

   fwd_match_t [NQ-1:0]             m_even_c;
   fwd_match_t [NQ-1:0]             m_odd_c;
   logic [NQ-1:0]                   pick_odd_c;
   logic [NQ-1:0]                   fwd_hit_c;
   logic [NQ-1:0]                   fwd_stall_c;
   logic [NQ-1:0][DATA_W-1:0]       fwd_data_c;

   spu_wb_lane u_lane_even (
      .clk           (clk),
      .rst_n         (reset),
      .issue_valid_i (bus.issue_valid_even),
      .issue_addr_i  (bus.issue_addr_even),
      .issue_wr_i    (bus.issue_wr_even),
      .res_valid_i   (bus.res_valid_even),
      .res_stage_i   (bus.res_stage_even),
      .res_data_i    (bus.res_data_even),
      .fwd_stages_o  (stages_even),
      .rt_o          (bus.rt_even),
      .rt_addr_o     (rt_addr_even),
      .reg_write_c_o (reg_write_even_c),
      .err_c_o       (err_even_c)
   );

   spu_wb_lane u_lane_odd (
      .clk           (clk),
      .rst_n         (reset),
      .issue_valid_i (bus.issue_valid_odd),
      .issue_addr_i  (bus.issue_addr_odd),
      .issue_wr_i    (bus.issue_wr_odd),
      .res_valid_i   (bus.res_valid_odd),
      .res_stage_i   (bus.res_stage_odd),
      .res_data_i    (bus.res_data_odd),
      .fwd_stages_o  (stages_odd),
      .rt_o          (bus.rt_odd),
      .rt_addr_o     (rt_addr_odd),
      .reg_write_c_o (reg_write_odd_c),
      .err_c_o       (err_odd_c)
   );

   // Youngest match across both lanes; odd lane wins a same-stage tie.
   // A not-yet-ready winner stalls the query even if an older value is ready.
   always_comb begin
      m_even_c    = '0;
      m_odd_c     = '0;
      pick_odd_c  = '0;
      fwd_hit_c   = '0;
      fwd_stall_c = '0;
      fwd_data_c  = '0;
      for (int q = 0; q < int'(NQ); q++) begin
         m_even_c[q]   = youngest_match(stages_even, bus.fwd_addr[q]);
         m_odd_c[q]    = youngest_match(stages_odd,  bus.fwd_addr[q]);
         pick_odd_c[q] = m_odd_c[q].hit &&
                         (!m_even_c[q].hit || (m_odd_c[q].stage <= m_even_c[q].stage));
         if (pick_odd_c[q]) begin
            fwd_hit_c[q]   = m_odd_c[q].ready;
            fwd_stall_c[q] = ~m_odd_c[q].ready;
            fwd_data_c[q]  = m_odd_c[q].ready ? m_odd_c[q].data : '0;
         end else if (m_even_c[q].hit) begin
            fwd_hit_c[q]   = m_even_c[q].ready;
            fwd_stall_c[q] = ~m_even_c[q].ready;
            fwd_data_c[q]  = m_even_c[q].ready ? m_even_c[q].data : '0;
         end
      end
   end

   assign collide_c = reg_write_even_c & reg_write_odd_c & (rt_addr_even == rt_addr_odd);

   // Sticky until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (err_even_c || err_odd_c || collide_c) begin
         err_q <= 1'b1;
      end
   end

   assign bus.rt_addr_even   = rt_addr_even;
   assign bus.rt_addr_odd    = rt_addr_odd;
   assign bus.reg_write_even = reg_write_even_c;
   assign bus.reg_write_odd  = reg_write_odd_c;
   assign bus.fwd_hit        = fwd_hit_c;
   assign bus.fwd_stall      = fwd_stall_c;
   assign bus.fwd_data       = fwd_data_c;
   assign bus.err            = err_q;

endmodule

// File: tb/tb_spu_writeback_pipe.sv
// Bench for spu_writeback_pipe: directed scenarios plus random traffic,
// compared each cycle against an instruction-age reference model.
module tb_spu_writeback_pipe;
   import spu_wb_pkg::*;

   typedef struct {
      int                lane;
      bit                wr;
      bit [ADDR_W-1:0]   addr;
      bit                ready;
      bit [DATA_W-1:0]   data;
      int                age;
   } rec_t;

   localparam logic [DATA_W-1:0] DATA_A = 128'h000A0000_00000000_00000000_00000000;
   localparam logic [DATA_W-1:0] DATA_B = 128'h000B0000_00000000_00000000_00000000;
   localparam logic [DATA_W-1:0] DATA_E = 128'h11112222_33334444_55556666_77778888;
   localparam logic [DATA_W-1:0] DATA_O = 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000;

   logic clk;
   logic reset;

   spu_writeback_pipe_if bus ();

   spu_writeback_pipe dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   rec_t recs[$];
   bit   err_m;

   logic                      iv[2];
   logic                      iw[2];
   logic                      rv[2];
   logic [ADDR_W-1:0]         ia[2];
   logic [STAGE_W-1:0]        rs[2];
   logic [DATA_W-1:0]         rd[2];
   logic [NQ-1:0][ADDR_W-1:0] fa;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_stim();
      for (int l = 0; l < 2; l++) begin
         iv[l] = 1'b0; iw[l] = 1'b0; rv[l] = 1'b0;
         ia[l] = '0;   rs[l] = '0;   rd[l] = '0;
      end
   endtask

   task automatic apply_stim();
      bus.issue_valid_even = iv[0]; bus.issue_addr_even = ia[0]; bus.issue_wr_even = iw[0];
      bus.issue_valid_odd  = iv[1]; bus.issue_addr_odd  = ia[1]; bus.issue_wr_odd  = iw[1];
      bus.res_valid_even   = rv[0]; bus.res_stage_even  = rs[0]; bus.res_data_even = rd[0];
      bus.res_valid_odd    = rv[1]; bus.res_stage_odd   = rs[1]; bus.res_data_odd  = rd[1];
      bus.fwd_addr         = fa;
   endtask

   // Reference: each in-flight instruction carries its age (stages since issue).
   task automatic model_step();
      rec_t            nq[$];
      bit              hit;
      bit              t_we[2];
      bit [ADDR_W-1:0] t_ad[2];
      t_we[0] = 0; t_we[1] = 0; t_ad[0] = '0; t_ad[1] = '0;
      foreach (recs[i]) begin
         if (recs[i].age == int'(DEPTH)) begin
            if (recs[i].wr && !recs[i].ready) err_m = 1;
            t_we[recs[i].lane] = recs[i].wr && recs[i].ready;
            t_ad[recs[i].lane] = recs[i].addr;
         end
      end
      if (t_we[0] && t_we[1] && (t_ad[0] == t_ad[1])) err_m = 1;
      for (int l = 0; l < 2; l++) begin
         if (rv[l]) begin
            hit = 0;
            if (int'(rs[l]) >= 1 && int'(rs[l]) <= int'(DEPTH) - 1) begin
               foreach (recs[i]) begin
                  if (recs[i].lane == l && recs[i].age == int'(rs[l])) begin
                     recs[i].ready = 1;
                     recs[i].data  = rd[l];
                     hit = 1;
                  end
               end
            end
            if (!hit) err_m = 1;
         end
      end
      foreach (recs[i]) begin
         recs[i].age++;
         if (recs[i].age <= int'(DEPTH)) nq.push_back(recs[i]);
      end
      for (int l = 0; l < 2; l++) begin
         if (iv[l]) begin
            rec_t r;
            r.lane = l; r.wr = iw[l]; r.addr = ia[l]; r.ready = 0; r.data = '0; r.age = 1;
            nq.push_back(r);
         end
      end
      recs = nq;
   endtask

   task automatic compare_model();
      logic [DATA_W-1:0] e_rt[2];
      logic [ADDR_W-1:0] e_ad[2];
      logic              e_we[2];
      logic [NQ-1:0]     e_hit;
      logic [NQ-1:0]     e_stall;
      logic [DATA_W-1:0] e_dat;
      int                best;
      for (int l = 0; l < 2; l++) begin
         e_rt[l] = '0; e_ad[l] = '0; e_we[l] = 1'b0;
      end
      foreach (recs[i]) begin
         if (recs[i].age == int'(DEPTH)) begin
            e_rt[recs[i].lane] = recs[i].data;
            e_ad[recs[i].lane] = recs[i].addr;
            e_we[recs[i].lane] = recs[i].wr && recs[i].ready;
         end
      end
      check("rt_even",        bus.rt_even,                   e_rt[0]);
      check("rt_addr_even",   DATA_W'(bus.rt_addr_even),     DATA_W'(e_ad[0]));
      check("reg_write_even", DATA_W'(bus.reg_write_even),   DATA_W'(e_we[0]));
      check("rt_odd",         bus.rt_odd,                    e_rt[1]);
      check("rt_addr_odd",    DATA_W'(bus.rt_addr_odd),      DATA_W'(e_ad[1]));
      check("reg_write_odd",  DATA_W'(bus.reg_write_odd),    DATA_W'(e_we[1]));
      e_hit = '0; e_stall = '0;
      for (int q = 0; q < int'(NQ); q++) begin
         best  = -1;
         e_dat = '0;
         foreach (recs[i]) begin
            if (recs[i].age >= 2 && recs[i].wr && recs[i].addr == fa[q]) begin
               if (best < 0 || recs[i].age < recs[best].age ||
                   (recs[i].age == recs[best].age && recs[i].lane == 1))
                  best = i;
            end
         end
         if (best >= 0) begin
            e_hit[q]   = recs[best].ready;
            e_stall[q] = !recs[best].ready;
            if (recs[best].ready) e_dat = recs[best].data;
         end
         check($sformatf("fwd_data[%0d]", q), bus.fwd_data[q], e_dat);
      end
      check("fwd_hit",   DATA_W'(bus.fwd_hit),   DATA_W'(e_hit));
      check("fwd_stall", DATA_W'(bus.fwd_stall), DATA_W'(e_stall));
      check("err",       DATA_W'(bus.err),       DATA_W'(err_m));
   endtask

   // Drive the staged inputs for one cycle, take the edge, then compare.
   task automatic tick();
      apply_stim();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
      clear_stim();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      recs.delete();
      err_m = 0;
      clear_stim();
      apply_stim();
      #2;
      compare_model();
      check("rst_err", DATA_W'(bus.err), '0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic rand_stim();
      for (int l = 0; l < 2; l++) begin
         int cand[$];
         iv[l] = ($urandom_range(0, 3) != 0);
         ia[l] = ADDR_W'($urandom_range(0, 7));
         iw[l] = ($urandom_range(0, 4) != 0);
         rv[l] = 1'b0;
         foreach (recs[i])
            if (recs[i].lane == l && !recs[i].ready && recs[i].age < int'(DEPTH))
               cand.push_back(recs[i].age);
         if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
            rv[l] = 1'b1;
            rs[l] = STAGE_W'(cand[$urandom_range(0, cand.size() - 1)]);
            rd[l] = {$urandom, $urandom, $urandom, $urandom};
         end
         if ($urandom_range(0, 40) == 0) begin
            rv[l] = 1'b1;
            rs[l] = STAGE_W'($urandom_range(0, 7));
            rd[l] = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      for (int q = 0; q < int'(NQ); q++) fa[q] = ADDR_W'($urandom_range(0, 7));
   endtask

   initial begin
      fa = '0;
      clear_stim();
      do_reset();
      repeat (3) tick();

      // Three entries in flight, then reset: nothing may be written back.
      iv[0] = 1; ia[0] = 7'd1; iw[0] = 1; tick();
      iv[1] = 1; ia[1] = 7'd2; iw[1] = 1; rv[0] = 1; rs[0] = 3'd1; rd[0] = DATA_E; tick();
      iv[0] = 1; ia[0] = 7'd3; iw[0] = 1; rv[1] = 1; rs[1] = 3'd1; rd[1] = DATA_O; tick();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("midrst_we", DATA_W'(bus.reg_write_even | bus.reg_write_odd), '0);
      end

      // Latency 2 on the even lane.
      do_reset();
      fa = '0; fa[0] = 7'd5;
      iv[0] = 1; ia[0] = 7'd5; iw[0] = 1; tick();
      tick();
      check("lat2_stall_e1", DATA_W'(bus.fwd_stall[0]), DATA_W'(1));
      rv[0] = 1; rs[0] = 3'd2; rd[0] = DATA_A; tick();
      check("lat2_hit_e2",  DATA_W'(bus.fwd_hit[0]), DATA_W'(1));
      check("lat2_data_e2", bus.fwd_data[0], DATA_A);
      for (int e = 3; e <= 6; e++) begin
         tick();
         check("lat2_we", DATA_W'(bus.reg_write_even), DATA_W'(e == 6));
      end
      check("lat2_addr", DATA_W'(bus.rt_addr_even), DATA_W'(5));
      check("lat2_rt",   bus.rt_even, DATA_A);
      tick();
      check("lat2_we_e7", DATA_W'(bus.reg_write_even), '0);
      check("lat2_err",   DATA_W'(bus.err), '0);

      // Odd-lane producer, forwarded through query 0.
      do_reset();
      fa = '0; fa[0] = 7'd7;
      iv[1] = 1; ia[1] = 7'd7; iw[1] = 1; tick();
      check("xl_stall_e0", DATA_W'(bus.fwd_stall[0]), '0);
      for (int e = 1; e <= 5; e++) begin
         tick();
         check("xl_stall", DATA_W'(bus.fwd_stall[0]), DATA_W'(1));
         check("xl_hit0",  DATA_W'(bus.fwd_hit[0]),   '0);
      end
      rv[1] = 1; rs[1] = 3'd6; rd[1] = DATA_B; tick();
      check("xl_hit",   DATA_W'(bus.fwd_hit[0]),   DATA_W'(1));
      check("xl_nost",  DATA_W'(bus.fwd_stall[0]), '0);
      check("xl_data",  bus.fwd_data[0], DATA_B);
      check("xl_we",    DATA_W'(bus.reg_write_odd), DATA_W'(1));

      // Younger unready match hides an older ready one.
      do_reset();
      fa = '0; fa[0] = 7'd9;
      iv[0] = 1; ia[0] = 7'd9; iw[0] = 1; tick();
      rv[0] = 1; rs[0] = 3'd1; rd[0] = DATA_E; tick();
      iv[1] = 1; ia[1] = 7'd9; iw[1] = 1; tick();
      check("yw_old_hit", bus.fwd_data[0], DATA_E);
      tick();
      check("yw_stall", DATA_W'(bus.fwd_stall[0]), DATA_W'(1));
      check("yw_hit",   DATA_W'(bus.fwd_hit[0]),   '0);
      check("yw_data",  bus.fwd_data[0], '0);

      // Same stage, same address, both ready.
      do_reset();
      fa = '0; fa[0] = 7'd3;
      iv[0] = 1; ia[0] = 7'd3; iw[0] = 1; iv[1] = 1; ia[1] = 7'd3; iw[1] = 1; tick();
      rv[0] = 1; rs[0] = 3'd1; rd[0] = DATA_E; rv[1] = 1; rs[1] = 3'd1; rd[1] = DATA_O; tick();
      check("ss_data", bus.fwd_data[0], DATA_O);
      repeat (5) tick();
      check("ss_we_even", DATA_W'(bus.reg_write_even), DATA_W'(1));
      check("ss_we_odd",  DATA_W'(bus.reg_write_odd),  DATA_W'(1));
      tick();
      check("ss_err", DATA_W'(bus.err), DATA_W'(1));

      // Missing result.
      do_reset();
      iv[0] = 1; ia[0] = 7'd4; iw[0] = 1; tick();
      repeat (6) tick();
      check("miss_we",  DATA_W'(bus.reg_write_even), '0);
      check("miss_err0", DATA_W'(bus.err), '0);
      tick();
      check("miss_err", DATA_W'(bus.err), DATA_W'(1));
      repeat (2) tick();
      check("miss_sticky", DATA_W'(bus.err), DATA_W'(1));

      // res_stage = 0.
      do_reset();
      iv[0] = 1; ia[0] = 7'd6; iw[0] = 1; tick();
      rv[0] = 1; rs[0] = 3'd0; rd[0] = DATA_E; tick();
      check("st0_err", DATA_W'(bus.err), DATA_W'(1));
      tick();
      check("st0_sticky", DATA_W'(bus.err), DATA_W'(1));

      // Result for an empty stage.
      do_reset();
      rv[1] = 1; rs[1] = 3'd3; rd[1] = DATA_O; tick();
      check("empty_err", DATA_W'(bus.err), DATA_W'(1));
      tick();
      check("empty_sticky", DATA_W'(bus.err), DATA_W'(1));

      // Random traffic with periodic resets.
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int i = 0; i < 200; i++) begin
            rand_stim();
            tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
